// File: rtl/serial_align.sv
// Word aligner for the LVDS receiver. It searches all 16 bit offsets for the training word,
// confirms the match over consecutive words, then emits bit-aligned data words.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_HUNT   | search all 16 offsets of {prev, DIN} for SYNC_PAT
// S_VERIFY | confirm SYNC_PAT at the chosen offset until LOCK_CNT hits
// S_LOCK   | aligned; every DIN_VLD word is emitted one cycle later
module serial_align #(
  parameter logic [15:0] SYNC_PAT = 16'hF628,
  parameter int          LOCK_CNT = 4,
  parameter int          SLIP_W   = 8
) (
  input  logic              CLKS,
  input  logic              RSTXS,
  input  logic              DIN_VLD,
  input  logic [15:0]       DIN,
  input  logic              RESYNC,
  output logic [15:0]       DOUT,
  output logic              DOUT_VLD,
  output logic              LOCKED,
  output logic [3:0]        OFFSET,
  output logic [SLIP_W-1:0] SLIP_CNT
);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCK} state_t;

  localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_prev;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [3:0]        r_offset;
  logic [3:0]        w_offset_nxt;
  logic [SLIP_W-1:0] r_slip;
  logic [15:0]       r_dout;
  logic              r_dout_vld;
  logic              w_slip_inc;
  logic              w_out_en;
  logic [31:0]       w_win;
  logic [15:0]       w_cand;
  logic              w_hit;
  logic [3:0]        w_hit_k;

  assign w_win  = {r_prev, DIN};
  assign w_cand = w_win[r_offset +: 16];

  // Scan from the top down so the last assignment leaves the lowest matching offset.
  always_comb begin
    w_hit   = 1'b0;
    w_hit_k = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (w_win[k +: 16] == SYNC_PAT) begin
        w_hit   = 1'b1;
        w_hit_k = 4'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_offset_nxt = r_offset;
    w_slip_inc   = 1'b0;
    w_out_en     = 1'b0;
    if (RESYNC) begin
      w_state_nxt = S_HUNT;
      w_cnt_nxt   = 4'd0;
      w_slip_inc  = (r_state != S_HUNT);
    end else if (DIN_VLD) begin
      case (r_state)
        S_HUNT: begin
          if (w_hit) begin
            w_offset_nxt = w_hit_k;
            w_cnt_nxt    = 4'd1;
            w_state_nxt  = (LOCK_CNT == 1) ? S_LOCK : S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (w_cand == SYNC_PAT) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if ((r_cnt + 4'd1) == LOCK_CNT_W) w_state_nxt = S_LOCK;
          end else begin
            w_state_nxt = S_HUNT;
            w_cnt_nxt   = 4'd0;
            w_slip_inc  = 1'b1;
          end
        end
        S_LOCK:  w_out_en = 1'b1;
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) r_state <= S_HUNT;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      r_prev     <= 16'd0;
      r_cnt      <= 4'd0;
      r_offset   <= 4'd0;
      r_slip     <= '0;
      r_dout     <= 16'd0;
      r_dout_vld <= 1'b0;
    end else begin
      if (DIN_VLD) r_prev <= DIN;
      r_cnt      <= w_cnt_nxt;
      r_offset   <= w_offset_nxt;
      r_dout_vld <= w_out_en;
      if (w_out_en) r_dout <= w_cand;
      if (w_slip_inc && (r_slip != {SLIP_W{1'b1}}))
        r_slip <= r_slip + {{(SLIP_W-1){1'b0}}, 1'b1};
    end
  end

  assign DOUT     = r_dout;
  assign DOUT_VLD = r_dout_vld;
  assign LOCKED   = (r_state == S_LOCK);
  assign OFFSET   = r_offset;
  assign SLIP_CNT = r_slip;

endmodule

// File: tb/tb_serial_align.sv
// Randomised scoreboard bench for serial_align: a behavioural model predicts outputs,
// expected data words are queued and popped by an independent monitor.
module tb_serial_align;

  localparam logic [15:0] PAT  = 16'hF628;
  localparam int          LCNT = 4;

  logic        CLKS = 1'b0;
  logic        RSTXS;
  logic        DIN_VLD;
  logic [15:0] DIN;
  logic        RESYNC;
  logic [15:0] DOUT;
  logic        DOUT_VLD;
  logic        LOCKED;
  logic [3:0]  OFFSET;
  logic [7:0]  SLIP_CNT;

  serial_align #(.SYNC_PAT(PAT), .LOCK_CNT(LCNT), .SLIP_W(8)) dut (
    .CLKS(CLKS), .RSTXS(RSTXS), .DIN_VLD(DIN_VLD), .DIN(DIN), .RESYNC(RESYNC),
    .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .LOCKED(LOCKED), .OFFSET(OFFSET), .SLIP_CNT(SLIP_CNT)
  );

  always #5 CLKS = ~CLKS;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // Reference model: mode 0 = hunting, 1 = verifying, 2 = locked
  int          m_mode;
  logic [15:0] m_prev;
  int          m_cnt;
  int          m_off;
  int          m_slip;
  logic [15:0] m_dout;
  logic        m_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v, input int k);
    return (v << k) | (v >> (16 - k));
  endfunction

  function automatic int search(input logic [15:0] p, input logic [15:0] d);
    logic [31:0] w;
    w = {p, d};
    for (int k = 0; k < 16; k++)
      if (16'(w >> k) == PAT) return k;
    return -1;
  endfunction

  task automatic mdl_reset();
    m_mode = 0; m_prev = 16'd0; m_cnt = 0; m_off = 0; m_slip = 0;
    m_dout = 16'd0; m_vld = 1'b0;
    exp_q.delete();
  endtask

  task automatic mdl_step(input logic vld, input logic [15:0] d, input logic rs);
    logic [15:0] cand;
    int k;
    cand  = 16'({m_prev, d} >> m_off);
    m_vld = 1'b0;
    if (rs) begin
      if (m_mode != 0 && m_slip < 255) m_slip++;
      m_mode = 0;
      m_cnt  = 0;
    end else if (vld) begin
      if (m_mode == 0) begin
        k = search(m_prev, d);
        if (k >= 0) begin
          m_off  = k;
          m_cnt  = 1;
          m_mode = (LCNT == 1) ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (cand == PAT) begin
          m_cnt++;
          if (m_cnt == LCNT) m_mode = 2;
        end else begin
          m_mode = 0;
          m_cnt  = 0;
          if (m_slip < 255) m_slip++;
        end
      end else begin
        m_dout = cand;
        m_vld  = 1'b1;
        exp_q.push_back(cand);
      end
    end
    if (vld) m_prev = d;
  endtask

  task automatic check_state();
    chk("locked", 32'(LOCKED), 32'(m_mode == 2));
    chk("offset", 32'(OFFSET), 32'(m_off));
    chk("slip_cnt", 32'(SLIP_CNT), 32'(m_slip));
    chk("dout_vld", 32'(DOUT_VLD), 32'(m_vld));
    chk("dout_hold", 32'(DOUT), 32'(m_dout));
  endtask

  // Called at posedge+1; returns at the next posedge+1 after checking state.
  task automatic step(input logic vld, input logic [15:0] d, input logic rs);
    DIN_VLD = vld; DIN = d; RESYNC = rs;
    mdl_step(vld, d, rs);
    @(posedge CLKS); #1;
    DIN_VLD = 1'b0; RESYNC = 1'b0; DIN = 16'($urandom);
    check_state();
  endtask

  task automatic word(input logic [15:0] d, input int gap);
    step(1'b1, d, 1'b0);
    repeat (gap) step(1'b0, 16'($urandom), 1'b0);
  endtask

  always @(negedge CLKS) begin
    if (RSTXS && DOUT_VLD) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_unexpected: got dout %0h expected no output at %0t", DOUT, $time);
      end else begin
        chk("sb_dout", 32'(DOUT), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RSTXS = 1'b0; DIN_VLD = 1'b0; DIN = 16'd0; RESYNC = 1'b0;
    mdl_reset();
    repeat (2) @(posedge CLKS);
    #3 RSTXS = 1'b1;
    @(posedge CLKS); #1;
    check_state();

    // Lock at offset 5, words every 3rd cycle, then data through the window
    repeat (5) word(rotl(PAT, 5), 2);
    word(16'h1234, 2);
    for (int i = 0; i < 4; i++) word(16'($urandom), $urandom_range(0, 2));

    // RESYNC in LOCK together with DIN_VLD, then RESYNC in HUNT
    step(1'b1, 16'h5A5A, 1'b1);
    step(1'b0, 16'h0, 1'b1);

    // Offset 0
    repeat (5) word(PAT, 1);
    word(16'hABCD, 1);

    // Verify failure then relock
    step(1'b0, 16'h0, 1'b1);
    word(rotl(PAT, 5), 0); word(rotl(PAT, 5), 0); word(16'h0000, 0);
    repeat (5) word(rotl(PAT, 5), 0);
    word(16'h8001, 1);

    // Asynchronous reset while verifying
    step(1'b0, 16'h0, 1'b1);
    repeat (3) word(rotl(PAT, 9), 0);
    #2 RSTXS = 1'b0;
    #1;
    mdl_reset();
    chk("rst_dout", 32'(DOUT), 32'h0);
    chk("rst_dout_vld", 32'(DOUT_VLD), 32'h0);
    chk("rst_locked", 32'(LOCKED), 32'h0);
    chk("rst_offset", 32'(OFFSET), 32'h0);
    chk("rst_slip", 32'(SLIP_CNT), 32'h0);
    repeat (2) @(posedge CLKS);
    #4 RSTXS = 1'b1;
    @(posedge CLKS); #1;
    repeat (6) word(rotl(PAT, 9), 0);
    word(16'h7E11, 0);

    // Saturate the slip counter
    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      word(rotl(PAT, 3), 0); word(rotl(PAT, 3), 0); word(16'h0000, 0);
    end
    chk("slip_sat", 32'(SLIP_CNT), 32'hFF);

    // Random bursts: training at a random offset, then random data with occasional RESYNC
    for (int b = 0; b < 12; b++) begin
      int k;
      k = $urandom_range(0, 15);
      step(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < LCNT + 2; i++) word(rotl(PAT, k), $urandom_range(0, 2));
      for (int i = 0; i < 10; i++)
        step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 19) == 0));
    end

    repeat (3) step(1'b0, 16'h0, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
